// File: rtl/divider_if.sv
// Handshake/bus bundle between the issue port and the HI/LO divider.
// Carries the request (operands, sign mode, ROB and HI/LO PRF pointers) and the completion result.
// master = issuing side, slave = divider.
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 4
`endif

interface divider_if #(parameter int W = 32);
    // request side
    logic                              is_signed;
    logic                              go;
    logic [W-1:0]                      src_A;
    logic [W-1:0]                      src_B;
    logic [`LG_ROB_ENTRIES-1:0]        rob_ptr_in;
    logic [`LG_HILO_PRF_ENTRIES-1:0]   hilo_prf_ptr_in;
    // response side
    logic                              ready;
    logic [2*W-1:0]                    y;
    logic                              complete;
    logic [`LG_ROB_ENTRIES-1:0]        rob_ptr_out;
    logic                              hilo_prf_ptr_val_out;
    logic [`LG_HILO_PRF_ENTRIES-1:0]   hilo_prf_ptr_out;

    modport master (
        output is_signed, go, src_A, src_B, rob_ptr_in, hilo_prf_ptr_in,
        input  ready, y, complete, rob_ptr_out, hilo_prf_ptr_val_out, hilo_prf_ptr_out
    );

    modport slave (
        input  is_signed, go, src_A, src_B, rob_ptr_in, hilo_prf_ptr_in,
        output ready, y, complete, rob_ptr_out, hilo_prf_ptr_val_out, hilo_prf_ptr_out
    );
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for the HI/LO path; y = {remainder, quotient}.
// Latency 35 cycles from go acceptance to the complete pulse (3 for early-out ops when DIV_EARLY_OUT_EN is defined).
// One op in flight; ready=1 only in IDLE, and a go seen while not ready is dropped.
//
// Ports: clk, reset (synchronous, active-low), bus (divider_if.slave: go/operands/pointers in,
// ready/y/complete/pointers out). Optional feature macro: DIV_EARLY_OUT_EN (skip the shift-subtract
// loop when B=0 or |A|<|B|).
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 4
`endif

module divider #(
    parameter int W = 32
) (
    input  logic      clk,
    input  logic      reset,
    divider_if.slave  bus
);
    localparam int CNT_W = $clog2(W);
    localparam int RW    = `LG_ROB_ENTRIES;
    localparam int HW    = `LG_HILO_PRF_ENTRIES;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PREP   = 3'd1;
    localparam logic [2:0] DIVIDE = 3'd2;
    localparam logic [2:0] FIXUP  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [W-1:0]     a_q, a_d;          // raw dividend as issued
    logic [W-1:0]     b_q, b_d;          // raw divisor as issued
    logic             sgn_q, sgn_d;
    logic [RW-1:0]    rob_q, rob_d;
    logic [HW-1:0]    hilo_q, hilo_d;
    logic [W-1:0]     bmag_q, bmag_d;    // |B|
    logic [W-1:0]     rem_q, rem_d;      // partial remainder
    logic [W-1:0]     dvd_q, dvd_d;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [2*W-1:0]   y_q, y_d;
    logic [RW-1:0]    rob_out_q, rob_out_d;
    logic [HW-1:0]    hilo_out_q, hilo_out_d;
    logic             complete_q, complete_d;

    logic [W-1:0]     a_mag, b_mag;
    logic [W:0]       rem_sh, diff;
    logic [W-1:0]     quo_fix, rem_fix;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sgn_d      = sgn_q;
        rob_d      = rob_q;
        hilo_d     = hilo_q;
        bmag_d     = bmag_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        cnt_d      = cnt_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        y_d        = y_q;
        rob_out_d  = rob_out_q;
        hilo_out_d = hilo_out_q;
        complete_d = 1'b0;

        a_mag = (sgn_q && a_q[W-1]) ? (~a_q + 1'b1) : a_q;
        b_mag = (sgn_q && b_q[W-1]) ? (~b_q + 1'b1) : b_q;

        // W+1-bit trial subtract: the shifted remainder can exceed W bits' worth of |B|
        rem_sh = {rem_q, dvd_q[W-1]};
        diff   = rem_sh - {1'b0, bmag_q};

        // Divide by zero keeps the raw dividend as remainder and skips sign fixup
        if (b_q == '0) begin
            quo_fix = '1;
            rem_fix = a_q;
        end else begin
            quo_fix = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
            rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    a_d     = bus.src_A;
                    b_d     = bus.src_B;
                    sgn_d   = bus.is_signed;
                    rob_d   = bus.rob_ptr_in;
                    hilo_d  = bus.hilo_prf_ptr_in;
                    state_d = PREP;
                end
            end
            PREP: begin
                neg_quo_d = sgn_q & (a_q[W-1] ^ b_q[W-1]);
                neg_rem_d = sgn_q & a_q[W-1];
                bmag_d    = b_mag;
                rem_d     = '0;
                dvd_d     = a_mag;
                cnt_d     = CNT_W'(W-1);
                state_d   = DIVIDE;
`ifdef DIV_EARLY_OUT_EN
                // Quotient is known to be 0 (or the div-by-zero pattern): remainder is |A| already
                if ((b_q == '0) || (a_mag < b_mag)) begin
                    rem_d   = a_mag;
                    dvd_d   = '0;
                    state_d = FIXUP;
                end
`endif
            end
            DIVIDE: begin
                if (!diff[W]) begin
                    rem_d = diff[W-1:0];
                    dvd_d = {dvd_q[W-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[W-1:0];
                    dvd_d = {dvd_q[W-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIXUP: begin
                // Result registers load here so they are valid throughout the DONE cycle
                y_d        = {rem_fix, quo_fix};
                rob_out_d  = rob_q;
                hilo_out_d = hilo_q;
                complete_d = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sgn_q      <= 1'b0;
            rob_q      <= '0;
            hilo_q     <= '0;
            bmag_q     <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            y_q        <= '0;
            rob_out_q  <= '0;
            hilo_out_q <= '0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sgn_q      <= sgn_d;
            rob_q      <= rob_d;
            hilo_q     <= hilo_d;
            bmag_q     <= bmag_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            cnt_q      <= cnt_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            y_q        <= y_d;
            rob_out_q  <= rob_out_d;
            hilo_out_q <= hilo_out_d;
            complete_q <= complete_d;
        end
    end

    assign bus.ready                = (state_q == IDLE) && reset;
    assign bus.y                    = y_q;
    assign bus.complete             = complete_q;
    assign bus.hilo_prf_ptr_val_out = complete_q;
    assign bus.rob_ptr_out          = rob_out_q;
    assign bus.hilo_prf_ptr_out     = hilo_out_q;

endmodule

// File: tb/tb_divider.sv
// Randomized and directed bench for divider against a behavioural arithmetic model.
// Model result is plain integer division; timing is a busy window ending at the due cycle.
// A negedge process compares ready/complete/y/pointers every cycle.
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 4
`endif

module tb_divider;
    localparam int W  = 32;
    localparam int RW = `LG_ROB_ENTRIES;
    localparam int HW = `LG_HILO_PRF_ENTRIES;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    divider_if #(.W(W)) bus();
    divider #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sgn) begin
            uq = a / b;
            ur = a % b;
            return {ur, uq};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] mag(input bit sgn, input logic [31:0] v);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    function automatic int lat_for(input bit sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if ((b == 32'd0) || (mag(sgn, a) < mag(sgn, b))) return 3;
`endif
        return 35;
    endfunction

    bit            m_busy = 1'b0;
    int            m_due = 0;
    logic [63:0]   m_y = '0, h_y = '0;
    logic [RW-1:0] m_rob = '0, h_rob = '0;
    logic [HW-1:0] m_hilo = '0, h_hilo = '0;

    always @(negedge clk) begin
        bit exp_c, exp_r;
        exp_c = m_busy && (cyc == m_due);
        exp_r = (reset === 1'b1) && !m_busy;
        check("ready", 64'(bus.ready), 64'(exp_r));
        check("complete", 64'(bus.complete), 64'(exp_c));
        check("ptr_val", 64'(bus.hilo_prf_ptr_val_out), 64'(exp_c));
        check("y", bus.y, exp_c ? m_y : h_y);
        check("rob_out", 64'(bus.rob_ptr_out), 64'(exp_c ? m_rob : h_rob));
        check("hilo_out", 64'(bus.hilo_prf_ptr_out), 64'(exp_c ? m_hilo : h_hilo));
        if (reset !== 1'b1) begin
            m_busy = 1'b0;
            h_y    = '0;
            h_rob  = '0;
            h_hilo = '0;
        end else begin
            if (exp_c) begin
                m_busy = 1'b0;
                h_y    = m_y;
                h_rob  = m_rob;
                h_hilo = m_hilo;
            end
            if (exp_r && bus.go) begin
                m_busy = 1'b1;
                m_due  = cyc + lat_for(bus.is_signed, bus.src_A, bus.src_B);
                m_y    = ref_div(bus.is_signed, bus.src_A, bus.src_B);
                m_rob  = bus.rob_ptr_in;
                m_hilo = bus.hilo_prf_ptr_in;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int rob, input int hilo, output int c0);
        bus.is_signed       = sgn;
        bus.src_A           = a;
        bus.src_B           = b;
        bus.rob_ptr_in      = RW'(rob);
        bus.hilo_prf_ptr_in = HW'(hilo);
        bus.go              = 1'b1;
        c0                  = cyc;
        @(posedge clk); #1;
        bus.go              = 1'b0;
        // scramble operands so the DUT must have latched them
        bus.src_A           = $urandom;
        bus.src_B           = $urandom;
        bus.is_signed       = ~sgn;
        bus.rob_ptr_in      = RW'($urandom);
        bus.hilo_prf_ptr_in = HW'($urandom);
    endtask

    task automatic wait_complete(input string name, output logic [63:0] yo, output int cc, output int robo);
        cc   = -1;
        yo   = '0;
        robo = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.complete) begin
                yo   = bus.y;
                cc   = cyc;
                robo = int'(bus.rob_ptr_out);
                break;
            end
        end
        if (cc < 0) timeout_fail(name);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.ready !== 1'b1) timeout_fail(name);
    endtask

    task automatic run_op(input string name, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input int rob, input int hilo,
                          output logic [63:0] yo, output int c0, output int cc, output int robo);
        wait_ready(name);
        issue(sgn, a, b, rob, hilo, c0);
        wait_complete(name, yo, cc, robo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 300);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] yo, y1;
        int          c0, cc, c0b, ccb, robo, lat0;
        int          seen;
        bit          sgn;
        logic [31:0] a, b;

        reset               = 1'b0;
        bus.go              = 1'b0;
        bus.is_signed       = 1'b0;
        bus.src_A           = '0;
        bus.src_B           = '0;
        bus.rob_ptr_in      = '0;
        bus.hilo_prf_ptr_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.ready), 64'd0);
        check("rst_complete", 64'(bus.complete), 64'd0);
        check("rst_y", bus.y, 64'd0);
        check("rst_rob", 64'(bus.rob_ptr_out), 64'd0);
        // reset and go together: reset wins
        bus.go = 1'b1;
        @(posedge clk); #1;
        bus.go = 1'b0;
        reset  = 1'b1;
        #1;
        check("ready_after_rst", 64'(bus.ready), 64'd1);

        // 100 / 7 unsigned
        run_op("t_100_7", 1'b0, 32'd100, 32'd7, 5, 3, yo, c0, cc, robo);
        check("t_100_7_y", yo, 64'h00000002_0000000E);
        check("t_100_7_lat", 64'(cc - c0), 64'd35);
        check("t_100_7_rob", 64'(robo), 64'd5);
        @(negedge clk);
        check("t_100_7_pulse", 64'(bus.hilo_prf_ptr_val_out), 64'd0);

        // -7 / 2 signed and unsigned
        run_op("t_m7_2s", 1'b1, 32'hFFFF_FFF9, 32'd2, 1, 1, yo, c0, cc, robo);
        check("t_m7_2s_y", yo, 64'hFFFFFFFF_FFFFFFFD);
        run_op("t_m7_2u", 1'b0, 32'hFFFF_FFF9, 32'd2, 2, 2, yo, c0, cc, robo);
        check("t_m7_2u_y", yo, 64'h00000001_7FFFFFFC);

        // signed overflow
        run_op("t_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 3, 3, yo, c0, cc, robo);
        check("t_ovf_y", yo, 64'h00000000_80000000);
        check("t_ovf_lat", 64'(cc - c0), 64'd35);

        // divide by zero
        run_op("t_dz", 1'b1, 32'hFFFF_FFFB, 32'd0, 4, 4, yo, c0, cc, robo);
        check("t_dz_y", yo, 64'hFFFFFFFB_FFFFFFFF);
`ifdef DIV_EARLY_OUT_EN
        check("t_dz_lat", 64'(cc - c0), 64'd3);
`else
        check("t_dz_lat", 64'(cc - c0), 64'd35);
`endif

        // second go in cycle 10 is dropped
        wait_ready("t_drop");
        issue(1'b0, 32'd1000, 32'd10, 7, 1, c0);
        repeat (9) @(posedge clk);
        #1;
        issue(1'b0, 32'd5, 32'd5, 9, 2, c0b);
        wait_complete("t_drop", yo, cc, robo);
        check("t_drop_y", yo, 64'h00000000_00000064);
        check("t_drop_lat", 64'(cc - c0), 64'd35);
        check("t_drop_rob", 64'(robo), 64'd7);

        // reset in cycle 10 discards the op
        wait_ready("t_rst");
        issue(1'b0, 32'd77, 32'd3, 11, 3, c0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (bus.complete) seen++;
        end
        check("t_rst_nocpl", 64'(seen), 64'd0);
        run_op("t_rst_new", 1'b1, 32'd12345, 32'hFFFF_FFF6, 12, 1, yo, c0, cc, robo);
        check("t_rst_new_y", yo, 64'h00000005_FFFFFB2E);
        check("t_rst_new_lat", 64'(cc - c0), 64'd35);

        // back-to-back with held result
        run_op("t_b2b_a", 1'b0, 32'd50, 32'd8, 13, 2, y1, c0, cc, robo);
        run_op("t_b2b_b", 1'b0, 32'd99, 32'd9, 14, 3, yo, c0b, ccb, robo);
        check("t_b2b_a_y", y1, 64'h00000002_00000006);
        check("t_b2b_b_y", yo, 64'h00000000_0000000B);
        check("t_b2b_issue", 64'(c0b - c0), 64'd36);
        check("t_b2b_cycle", 64'(ccb - c0), 64'd71);
        check("t_b2b_rob", 64'(robo), 64'd14);

        // randomized ops
        for (int n = 0; n < 150; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = pick();
            b   = pick();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            wait_ready("rnd_ready");
            issue(sgn, a, b, n % 64, n % 16, c0);
            if ($urandom_range(0, 3) == 0) issue(~sgn, $urandom, $urandom, 63, 15, c0b);
            wait_complete("rnd_cpl", yo, cc, robo);
            check("rnd_y", yo, ref_div(sgn, a, b));
            lat0 = lat_for(sgn, a, b);
            check("rnd_lat", 64'(cc - c0), 64'(lat0));
        end

        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
